// File: rtl/nn_pkg.sv
// Shared types and helpers for the dense-layer engine: state encoding,
// clog2 with a floor of 1, and the shift/saturate narrowing step.
package nn_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } nn_state_e;

  function automatic int clog2_1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Arithmetic shift (floor) then clamp to the signed data_w range.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] acc,
                                                    input int frac_w,
                                                    input int data_w);
    logic signed [63:0] r, hi, lo;
    r  = acc >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/nn_mac.sv
// Single accumulator for one neuron at a time: clear-with-bias, accumulate,
// and a combinational narrowed/activated view of the running sum.
module nn_mac import nn_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int FRAC_W = 4,
  parameter int RELU   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] res
);

  logic signed [ACC_W-1:0]    acc_q, acc_d, prod, bias_al;
  logic signed [2*DATA_W-1:0] prod_full;
  logic signed [63:0]         narrowed;

  always_comb begin
    prod_full = (2*DATA_W)'(x) * (2*DATA_W)'(w);
    prod      = ACC_W'(prod_full);
    bias_al   = ACC_W'(b) <<< FRAC_W;
    acc_d     = acc_q;
    if (clr)         acc_d = bias_al + prod;
    else if (acc_en) acc_d = acc_q + prod;
    narrowed = sat_narrow(64'(acc_q), FRAC_W, DATA_W);
    res      = narrowed[DATA_W-1:0];
    if (RELU != 0 && narrowed < 0) res = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

endmodule

// File: rtl/nn_dense_engine.sv
// One fully-connected layer: fill N_IN samples, run N_OUT*(N_IN+1) MAC/finalize
// cycles, then drain N_OUT results with backpressure.
module nn_dense_engine import nn_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int FRAC_W = 4,
  parameter int ACC_W  = 20,
  parameter int RELU   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  w_we,
  input  logic [clog2_1(N_OUT*N_IN)-1:0]        w_addr,
  input  logic signed [DATA_W-1:0]              w_data,
  input  logic                                  b_we,
  input  logic [clog2_1(N_OUT)-1:0]             b_addr,
  input  logic signed [DATA_W-1:0]              b_data,
  output logic                                  cfg_err,
  input  logic                                  in_valid,
  input  logic signed [DATA_W-1:0]              in_data,
  output logic                                  in_ready,
  output logic                                  out_valid,
  output logic signed [DATA_W-1:0]              out_data,
  output logic [clog2_1(N_OUT)-1:0]             out_idx,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic                                  done
);

  localparam int IW = clog2_1(N_IN);
  localparam int OW = clog2_1(N_OUT);
  localparam int WW = clog2_1(N_OUT*N_IN);
  localparam int TW = $clog2(N_IN + 1);

  // Power-of-two depths keep every index in range for any parameter choice.
  logic signed [DATA_W-1:0] w_mem [2**WW];
  logic signed [DATA_W-1:0] b_mem [2**OW];
  logic signed [DATA_W-1:0] x_mem [2**IW];
  logic signed [DATA_W-1:0] y_mem [2**OW];

  nn_state_e                state_q, state_d;
  logic [IW-1:0]            cnt_q, cnt_d;
  logic [OW-1:0]            j_q, j_d, j_nxt;
  logic [TW-1:0]            t_q, t_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic [OW-1:0]            out_idx_q, out_idx_d;
  logic                     done_q, done_d, cfg_err_q, cfg_err_d;

  logic                     cfg_ok, in_xfer, mac_clr, mac_en, y_we;
  logic [IW-1:0]            xi;
  logic [WW-1:0]            wi;
  logic signed [DATA_W-1:0] mac_res;

  assign cfg_ok  = (state_q == FILL) && (cnt_q == '0);
  assign in_xfer = in_valid && (state_q == FILL);
  assign xi      = t_q[IW-1:0];
  assign wi      = WW'(int'(j_q) * N_IN + int'(xi));
  assign j_nxt   = j_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    j_d         = j_q;
    t_d         = t_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    done_d      = 1'b0;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    y_we        = 1'b0;
    cfg_err_d   = (w_we || b_we) && !cfg_ok;
    case (state_q)
      FILL: begin
        if (in_xfer) begin
          if (cnt_q == IW'(N_IN - 1)) begin
            cnt_d   = '0;
            j_d     = '0;
            t_d     = '0;
            state_d = COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (t_q == TW'(N_IN)) begin
          y_we = 1'b1;
          t_d  = '0;
          if (j_q == OW'(N_OUT - 1)) begin
            j_d     = '0;
            state_d = DRAIN;
          end else begin
            j_d = j_nxt;
          end
        end else begin
          mac_clr = (t_q == '0);
          mac_en  = (t_q != '0);
          t_d     = t_q + 1'b1;
        end
      end
      DRAIN: begin
        // First DRAIN cycle only loads the output register from y_mem[0].
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = y_mem[j_q];
          out_idx_d   = j_q;
        end else if (out_ready) begin
          if (j_q == OW'(N_OUT - 1)) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            j_d         = '0;
            state_d     = FILL;
          end else begin
            j_d        = j_nxt;
            out_data_d = y_mem[j_nxt];
            out_idx_d  = j_nxt;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      j_q         <= '0;
      t_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      j_q         <= j_d;
      t_q         <= t_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we && cfg_ok) w_mem[w_addr] <= w_data;
    if (b_we && cfg_ok) b_mem[b_addr] <= b_data;
    if (in_xfer)        x_mem[cnt_q]  <= in_data;
    if (y_we)           y_mem[j_q]    <= mac_res;
  end

  nn_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC_W(FRAC_W), .RELU(RELU)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .acc_en (mac_en),
    .x      (x_mem[xi]),
    .w      (w_mem[wi]),
    .b      (b_mem[j_q]),
    .res    (mac_res)
  );

  assign in_ready  = (state_q == FILL);
  assign busy      = (state_q != FILL) || (cnt_q != '0);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_nn_dense_engine.sv
// Directed bench: two engines share stimulus, one with ReLU and one linear.
module tb_nn_dense_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              w_we, b_we, in_valid, out_ready;
  logic [2:0]        w_addr;
  logic [0:0]        b_addr;
  logic signed [7:0] w_data, b_data, in_data;

  logic              cfg_err_a, in_ready_a, out_valid_a, busy_a, done_a;
  logic signed [7:0] out_data_a;
  logic [0:0]        out_idx_a;
  logic              cfg_err_b, in_ready_b, out_valid_b, busy_b, done_b;
  logic signed [7:0] out_data_b;
  logic [0:0]        out_idx_b;

  int total = 0;
  int bad = 0;
  int cfg_hits = 0;

  nn_dense_engine #(.RELU(1)) u_relu (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .cfg_err(cfg_err_a),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_idx(out_idx_a),
    .out_ready(out_ready), .busy(busy_a), .done(done_a)
  );

  nn_dense_engine #(.RELU(0)) u_lin (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .cfg_err(cfg_err_b),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_idx(out_idx_b),
    .out_ready(out_ready), .busy(busy_b), .done(done_b)
  );

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Stimulus tasks below are entered and left on a negedge.
  task automatic set_w(input logic [2:0] a, input logic signed [7:0] d);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(negedge clk);
    w_we = 1'b0;
    cfg_hits += int'(cfg_err_a);
  endtask

  task automatic set_b(input logic [0:0] a, input logic signed [7:0] d);
    b_we = 1'b1; b_addr = a; b_data = d;
    @(negedge clk);
    b_we = 1'b0;
    cfg_hits += int'(cfg_err_a);
  endtask

  task automatic load_all(input logic signed [7:0] w0, input logic signed [7:0] w1,
                          input logic signed [7:0] bb0, input logic signed [7:0] bb1);
    for (int a = 0; a < 4; a++) set_w(3'(a), w0);
    for (int a = 4; a < 8; a++) set_w(3'(a), w1);
    set_b(1'b0, bb0);
    set_b(1'b1, bb1);
  endtask

  task automatic send_frame(input logic signed [7:0] x0, input logic signed [7:0] x1,
                            input logic signed [7:0] x2, input logic signed [7:0] x3);
    logic signed [7:0] xs [4];
    xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = xs[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Gathers both outputs of a frame; ends on the negedge where done should be high.
  task automatic collect(output int lat, output logic signed [7:0] ra0, output logic signed [7:0] ra1,
                         output logic signed [7:0] rb0, output logic signed [7:0] rb1,
                         output int idx_err, output bit done_ok);
    lat = 0; idx_err = 0;
    ra0 = 'x; ra1 = 'x; rb0 = 'x; rb1 = 'x;
    while (!out_valid_a && lat < 200) begin @(negedge clk); lat++; end
    for (int k = 0; k < 2; k++) begin
      int wt = 0;
      while (!(out_valid_a && out_ready) && wt < 200) begin @(negedge clk); wt++; end
      if (k == 0) begin ra0 = out_data_a; rb0 = out_data_b; end
      else        begin ra1 = out_data_a; rb1 = out_data_b; end
      if (out_idx_a !== 1'(k) || out_idx_b !== 1'(k)) idx_err++;
      @(negedge clk);
    end
    done_ok = done_a && done_b && !out_valid_a && in_ready_a && !busy_a;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_a); end
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_a); end
    total++; if (out_data_a !== 8'sd0 || out_idx_a !== 1'b0) begin bad++; $display("FAIL reset_out_data got=%0d/%0d exp=0/0", out_data_a, out_idx_a); end
    total++; if (done_a !== 1'b0 || cfg_err_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL reset_flags done/cfg/busy got=%b%b%b exp=000", done_a, cfg_err_a, busy_a); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, ie; bit dk; logic signed [7:0] ra0, ra1, rb0, rb1;
    cfg_hits = 0;
    load_all(8'sd16, -8'sd16, 8'sd0, 8'sd0);
    total++; if (cfg_hits !== 0) begin bad++; $display("FAIL basic_cfg_err got=%0d exp=0", cfg_hits); end
    send_frame(8'sd16, 8'sd32, -8'sd16, 8'sd0);
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (lat !== 11) begin bad++; $display("FAIL basic_latency got=%0d exp=11", lat); end
    total++; if (ra0 !== 8'sd32 || ra1 !== 8'sd0) begin bad++; $display("FAIL basic_relu got=%0d,%0d exp=32,0", ra0, ra1); end
    total++; if (rb0 !== 8'sd32 || rb1 !== -8'sd32) begin bad++; $display("FAIL basic_linear got=%0d,%0d exp=32,-32", rb0, rb1); end
    total++; if (ie !== 0) begin bad++; $display("FAIL basic_idx got=%0d errors exp=0", ie); end
    total++; if (dk !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", dk); end
    @(negedge clk);
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done_a); end
  endtask

  task automatic test_back_to_back();
    int lat, ie; bit dk; logic signed [7:0] ra0, ra1, rb0, rb1;
    send_frame(8'sd127, 8'sd127, 8'sd127, 8'sd127);
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (ra0 !== 8'sd127 || rb1 !== -8'sd128 || ra1 !== 8'sd0) begin bad++; $display("FAIL b2b_first got=%0d,%0d,%0d exp=127,0,-128", ra0, ra1, rb1); end
    send_frame(8'sd16, 8'sd32, -8'sd16, 8'sd0);
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (lat !== 11 || rb0 !== 8'sd32 || rb1 !== -8'sd32 || dk !== 1'b1) begin bad++; $display("FAIL b2b_second got lat=%0d %0d,%0d done=%b exp lat=11 32,-32 done=1", lat, rb0, rb1, dk); end
  endtask

  task automatic test_saturation();
    int lat, ie; bit dk; logic signed [7:0] ra0, ra1, rb0, rb1;
    load_all(8'sd127, 8'sd127, 8'sd0, 8'sd0);
    send_frame(8'sd127, 8'sd127, 8'sd127, 8'sd127);
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (ra0 !== 8'sd127 || ra1 !== 8'sd127 || rb0 !== 8'sd127 || rb1 !== 8'sd127) begin bad++; $display("FAIL sat_pos got=%0d,%0d,%0d,%0d exp=127x4", ra0, ra1, rb0, rb1); end
    load_all(-8'sd127, -8'sd127, 8'sd0, 8'sd0);
    send_frame(8'sd127, 8'sd127, 8'sd127, 8'sd127);
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (rb0 !== -8'sd128 || rb1 !== -8'sd128) begin bad++; $display("FAIL sat_neg_linear got=%0d,%0d exp=-128,-128", rb0, rb1); end
    total++; if (ra0 !== 8'sd0 || ra1 !== 8'sd0) begin bad++; $display("FAIL sat_neg_relu got=%0d,%0d exp=0,0", ra0, ra1); end
  endtask

  task automatic test_bias_round();
    int lat, ie; bit dk; logic signed [7:0] ra0, ra1, rb0, rb1;
    load_all(8'sd0, 8'sd0, 8'sd5, -8'sd3);
    send_frame(8'sd10, 8'sd20, 8'sd30, 8'sd40);
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (rb0 !== 8'sd5 || rb1 !== -8'sd3) begin bad++; $display("FAIL bias_linear got=%0d,%0d exp=5,-3", rb0, rb1); end
    total++; if (ra0 !== 8'sd5 || ra1 !== 8'sd0) begin bad++; $display("FAIL bias_relu got=%0d,%0d exp=5,0", ra0, ra1); end
    set_b(1'b0, 8'sd0); set_b(1'b1, 8'sd0); set_w(3'd0, 8'sd1);
    send_frame(8'sd1, 8'sd0, 8'sd0, 8'sd0);
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (rb0 !== 8'sd0 || rb1 !== 8'sd0) begin bad++; $display("FAIL round_pos got=%0d,%0d exp=0,0", rb0, rb1); end
    set_w(3'd0, -8'sd1);
    send_frame(8'sd1, 8'sd0, 8'sd0, 8'sd0);
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (rb0 !== -8'sd1 || ra0 !== 8'sd0) begin bad++; $display("FAIL round_neg got=%0d relu=%0d exp=-1,0", rb0, ra0); end
  endtask

  task automatic test_backpressure();
    int lat, ie, errs, wt; bit dk; logic signed [7:0] ra0, ra1, rb0, rb1, d0;
    load_all(8'sd16, -8'sd16, 8'sd0, 8'sd0);
    out_ready = 1'b0;
    send_frame(8'sd16, 8'sd32, -8'sd16, 8'sd0);
    wt = 0;
    while (!out_valid_a && wt < 200) begin @(negedge clk); wt++; end
    d0 = out_data_a; errs = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (out_data_a !== d0 || out_idx_a !== 1'b0 || out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || busy_a !== 1'b1) errs++;
    end
    total++; if (d0 !== 8'sd32) begin bad++; $display("FAIL bp_first got=%0d exp=32", d0); end
    total++; if (errs !== 0) begin bad++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", errs); end
    out_ready = 1'b1;
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (ra0 !== 8'sd32 || rb1 !== -8'sd32 || ie !== 0 || dk !== 1'b1) begin bad++; $display("FAIL bp_release got=%0d,%0d idx_err=%0d done=%b exp=32,-32,0,1", ra0, rb1, ie, dk); end
  endtask

  task automatic test_cfg_guard();
    int lat, ie; bit dk; logic signed [7:0] ra0, ra1, rb0, rb1;
    send_frame(8'sd16, 8'sd32, -8'sd16, 8'sd0);
    @(negedge clk);
    cfg_hits = 0;
    set_w(3'd0, -8'sd100);
    total++; if (cfg_hits !== 1) begin bad++; $display("FAIL cfg_err_pulse got=%0d exp=1", cfg_hits); end
    @(negedge clk);
    total++; if (cfg_err_a !== 1'b0 || busy_a !== 1'b1) begin bad++; $display("FAIL cfg_err_clear got cfg=%b busy=%b exp=0,1", cfg_err_a, busy_a); end
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (ra0 !== 8'sd32 || rb1 !== -8'sd32) begin bad++; $display("FAIL cfg_ignored got=%0d,%0d exp=32,-32", ra0, rb1); end
    cfg_hits = 0;
    set_w(3'd0, 8'sd32);
    send_frame(8'sd16, 8'sd32, -8'sd16, 8'sd0);
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (cfg_hits !== 0 || rb0 !== 8'sd48) begin bad++; $display("FAIL cfg_accepted got err=%0d y0=%0d exp=0,48", cfg_hits, rb0); end
    set_w(3'd0, 8'sd16);
  endtask

  task automatic test_reset_mid();
    int lat, ie, seen; bit dk; logic signed [7:0] ra0, ra1, rb0, rb1;
    send_frame(8'sd16, 8'sd32, -8'sd16, 8'sd0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL rstmid_async got v/r/b/d=%b%b%b%b exp=0100", out_valid_a, in_ready_a, busy_a, done_a); end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid_a || done_a) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_quiet got=%0d active cycles exp=0", seen); end
    send_frame(8'sd16, 8'sd32, -8'sd16, 8'sd0);
    collect(lat, ra0, ra1, rb0, rb1, ie, dk);
    total++; if (lat !== 11 || ra0 !== 8'sd32 || ra1 !== 8'sd0 || rb1 !== -8'sd32) begin bad++; $display("FAIL rstmid_rerun got lat=%0d %0d,%0d,%0d exp lat=11 32,0,-32", lat, ra0, ra1, rb1); end
  endtask

  initial begin
    w_we = 1'b0; b_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    w_addr = '0; b_addr = '0; w_data = '0; b_data = '0; in_data = '0;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_bias_round();
    test_backpressure();
    test_cfg_guard();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_dense_engine.md
Name: nn_dense_engine

Overview:
- Parametrised single fully-connected layer engine with built-in input fill and output drain channels.
- Successor to the fixed 2-input/1-output generated network wrapper, generalised in width, input count, neuron count and activation mode.
- Adds run-time loadable weights and biases, output backpressure, and saturating fixed-point arithmetic.
- Instantiated per layer and chained: out_* of one engine feeds in_* of the next.

Parameters:
- DATA_W, 8: signed width of inputs, weights, biases and outputs.
- N_IN, 4: inputs per frame, at least 1.
- N_OUT, 2: neurons (outputs per frame), at least 1.
- FRAC_W, 4: fractional bits of the fixed-point format, 0 to DATA_W-1.
- ACC_W, 20: accumulator width; must be at least 2*DATA_W+clog2(N_IN)+1.
- RELU, 1: 1 = ReLU after saturation; 0 = identity.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- w_we  in  1  weight write strobe.
- w_addr  in  clog2(N_OUT*N_IN)  weight index, j*N_IN+i.
- w_data  in  DATA_W  signed weight value.
- b_we  in  1  bias write strobe.
- b_addr  in  clog2(N_OUT)  bias index.
- b_data  in  DATA_W  signed bias value.
- cfg_err  out  1  one-cycle pulse: a w_we or b_we arrived outside FILL with count 0.
- in_valid  in  1  input sample valid.
- in_data  in  DATA_W  signed input sample.
- in_ready  out  1  engine accepts a sample.
- out_valid  out  1  output sample valid.
- out_data  out  DATA_W  signed neuron result.
- out_idx  out  clog2(N_OUT)  neuron index of out_data.
- out_ready  in  1  downstream accepts.
- busy  out  1  high whenever state is not FILL or count is nonzero.
- done  out  1  one-cycle pulse after the last output transfers.

Behaviour:
- Reset (rst=0, async):
  - state=FILL; in/neuron/term counters and accumulator cleared.
  - in_ready=1, out_valid=0, out_data=0, out_idx=0, done=0, cfg_err=0, busy=0.
  - Weight, bias, input and result memories are not reset and keep their contents.
- Transfer rule: a transfer occurs on posedge when valid&ready are both high. Same rule on the input and output sides.
- FILL:
  - in_ready=1. Each transfer writes in_data to xbuf[cnt] and increments cnt.
  - The transfer with cnt==N_IN-1 moves to COMPUTE and resets cnt to 0.
- Config writes:
  - Accepted only in FILL with cnt==0; otherwise ignored and cfg_err pulses.
  - w_we and b_we in the same cycle are both accepted.
  - A config write simultaneous with the first input transfer is accepted.
- COMPUTE (in_ready=0):
  - Neuron j, term i, one MAC per cycle.
  - Cycle 0 of neuron j: acc = sext(bias[j])<<FRAC_W + x[0]*w[j][0].
  - Cycles 1..N_IN-1: acc += x[i]*w[j][i].
  - Finalize cycle:
    - r = acc >>> FRAC_W (arithmetic shift, rounds toward -inf).
    - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    - If RELU, negative results become 0.
    - Write ybuf[j].
  - After neuron N_OUT-1 finalizes, move to DRAIN.
  - COMPUTE lasts exactly N_OUT*(N_IN+1) cycles.
  - Accumulator never wraps: guaranteed by the ACC_W rule.
- DRAIN:
  - out_valid=1, out_data=ybuf[k], out_idx=k.
  - Each transfer increments k. out_data/out_idx stay stable while out_ready=0.
  - The transfer of k=N_OUT-1 moves to FILL, drops out_valid and pulses done in the next cycle.
  - in_ready returns to 1 in that same next cycle.
- Latency: the last input transfer to the first out_valid is N_OUT*(N_IN+1)+1 cycles.
- Back-to-back frames: the next frame may begin filling the cycle done is asserted.
- Reset mid-frame: the frame is abandoned; no out_valid or done follows.
- Width rules:
  - Products are DATA_W×DATA_W signed to 2*DATA_W, sign-extended to ACC_W.
  - The bias is aligned by <<FRAC_W before accumulation.

Decomposition:
- Package nn_pkg:
  - State enum {FILL, COMPUTE, DRAIN}.
  - Function sat_narrow(acc, FRAC_W, DATA_W).
  - Constant helper for clog2 with a floor of 1.
- Sub-module nn_mac:
  - Holds the accumulator with clear/accumulate/finalize controls.
  - Applies shift, saturation and ReLU.
  - Parametrised by DATA_W, ACC_W, FRAC_W, RELU.

Test Plan:
- Basic frame: N_IN=4, N_OUT=2, FRAC_W=4, RELU=1; w[0]={16,16,16,16}, w[1]={-16,-16,-16,-16}, biases 0; x={16,32,-16,0}. Expect out (idx0)=32, (idx1)=0; first out_valid 11 cycles after the last input; done one cycle after the second transfer.
- Saturation: all x=127, all w=127, bias 0. Expect 127 on both outputs. With RELU=0, w=-127 gives -128.
- Bias and rounding: RELU=0, w all 0, bias[0]=5, bias[1]=-3. Expect 5 and -3. Then x={1,0,0,0}, w[0][0]=1, bias 0: expect 0 (1>>>4); with w[0][0]=-1 expect -1.
- Backpressure: hold out_ready=0 for 7 cycles in DRAIN. Expect out_data/out_idx stable, in_ready=0, busy=1; transfers complete once out_ready=1.
- Config guard: w_we during COMPUTE. Expect cfg_err pulse and the weight unchanged (re-run frame gives the same result). A w_we in FILL with cnt==0 takes effect.
- Async reset mid-COMPUTE: rst low between edges. Expect outputs reset immediately, no done. The next frame with the same x gives the same results as the basic frame (memories retained).
